spdif_tx: RTL
=============

Name: spdif_tx

Overview:
S/PDIF (IEC 60958) transmitter. It is the output-side counterpart of the S/PDIF preamble-detecting receiver in the same design. It accepts interleaved 24-bit stereo PCM samples over a valid/ready handshake and builds 32-bit subframes: preamble, 24-bit audio, V, U, C and even parity. It biphase-mark encodes each subframe onto a single serial line. Its output timing matches the receiver: CLK_PER_SLOT clocks per half-bit slot, 64 slots per subframe.

Parameters:
CLK_PER_SLOT, 3, clk cycles per half-bit slot (>=1); default matches receiver sampling (24 clocks per preamble).
CS_WORD, 32'h00000000, channel-status bits 0..31 (bit n sent in frame n, both subframes); frames 32..191 send C=0.

Ports:
clk  in  1  system clock
i_rst_n  in  1  reset: asynchronous, active-low
i_data  in  24  PCM sample, two's complement; interleaved L,R,L,R...
i_valid  in  1  i_data valid
o_ready  out  1  holding register empty; transfer when i_valid & o_ready
o_spdif  out  1  biphase-mark serial output
o_underrun  out  1  1-clk pulse: subframe started with holding register empty
o_block_start  out  1  1-clk pulse coincident with first clock of Z preamble

Behaviour:
- Reset (async, i_rst_n=0): o_spdif=0, o_ready=0, o_underrun=0, o_block_start=0; state=WAIT; frame counter=0, subframe=A, slot/clock counters=0, holding empty.
- Rising edge after reset: o_ready=1.
- Holding register: one entry. It loads on the handshake; o_ready drops the next cycle. It empties when a subframe launches.
- If launch and handshake coincide, launch consumes the old entry and the new sample loads; o_ready stays 1.
- WAIT: o_spdif held 0. On the first handshake go to RUN; the first subframe launches the next clock.
- The first sample after reset is always channel A (left) of frame 0.
- RUN runs continuously. A subframe launches every 64*CLK_PER_SLOT clocks, on the clock after the last clock of slot 63.
- Launch builds the 32-bit word:
  - bits 4..27 = sample, LSB first;
  - V (bit 28) = 0, or 1 on underrun;
  - U (bit 29) = 0;
  - C (bit 30) = CS_WORD[frame] if frame<32, else 0;
  - P (bit 31) = XOR of bits 4..30 (even parity over 4..31).
- Underrun: holding register empty at launch -> send audio 0, V=1, pulse o_underrun. The channel still advances, so a late sample goes to the next channel.
- Preamble, slots 0..7, written for line level 0 before the preamble:
  - Z (frame 0, subframe A) = 11101000;
  - X (subframe A, frames 1..191) = 11100010;
  - Y (subframe B) = 11100100.
  - If the line is 1 when the preamble starts, send the bitwise inverse.
- Data bits (slots 8..63, two slots per bit): the line toggles at the start of every bit cell. For a 1 it toggles again at the mid-cell slot; for a 0 it holds.
- Each slot's level holds for exactly CLK_PER_SLOT clocks.
- o_spdif is registered. Its first preamble slot appears on the launch clock.
- Counters:
  - subframe toggles A/B each launch;
  - frame increments after subframe B and wraps 191->0;
  - o_block_start pulses on launches with frame=0, subframe A.
- Reset mid-subframe aborts immediately: line 0, partial subframe discarded, back to WAIT. There is no other way to return to WAIT.
- Latency: a sample accepted while the holding register is empty is sent in the next launched subframe. Samples are never dropped or reordered while i_valid respects the handshake.

Test Plan:
- Reset then single handshake i_data=24'h000000, CS_WORD=0, CLK_PER_SLOT=3 -> o_block_start pulse; first 24 o_spdif clocks = 111111111000111000000000 (Z); next 6 clocks = 111111 (bit0=0); subframe B begins with Y polarity matched to the line level.
- Stream L=24'h000001, R=24'h800000 -> subframe A bit4 cell has a mid toggle; P=1 for L; P=1 for R (bit 27 set); X/Y preambles follow. Receiver model recovers flags X=3'b001 or Y=3'b010 and the correct data.
- Stop i_valid after one sample -> next launch sends zero audio, V=1, o_underrun pulses once per starved subframe; o_ready stays 1.
- Run 192 full frames -> o_block_start pulses exactly every 384 subframes; Z appears only at frame 0A; CS_WORD=32'h00000004 gives C=1 only in frame 2 (both subframes).
- Hold i_valid=1 continuously -> exactly one handshake per 192 clocks (64*3); the sample order on the line equals the input order.
- Assert i_rst_n=0 mid-subframe at slot 30 -> o_spdif=0 within the same cycle (async), o_ready=0; after release it waits for a handshake and restarts with Z.

Source files
------------

// File: rtl/spdif_tx.sv
// S/PDIF (IEC 60958) transmitter: buffers stereo PCM samples, builds 32-bit subframes
// and biphase-mark encodes them at CLK_PER_SLOT clocks per half-bit slot.
module spdif_tx #(
  parameter int unsigned CLK_PER_SLOT = 3,
  parameter logic [31:0] CS_WORD      = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        i_rst_n,
  input  logic [23:0] i_data,
  input  logic        i_valid,
  output logic        o_ready,
  output logic        o_spdif,
  output logic        o_underrun,
  output logic        o_block_start
);

  localparam int unsigned CNT_W = (CLK_PER_SLOT > 1) ? $clog2(CLK_PER_SLOT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLK_PER_SLOT - 1);
  localparam logic [7:0]       FRAME_LAST = 8'd191;
  localparam logic [5:0]       SLOT_LAST  = 6'd63;
  localparam logic [7:0]       PRE_Z      = 8'b1110_1000;
  localparam logic [7:0]       PRE_X      = 8'b1110_0010;
  localparam logic [7:0]       PRE_Y      = 8'b1110_0100;

  typedef enum logic {ST_WAIT, ST_RUN} state_t;

  state_t             state;
  logic [7:0]         frame;
  logic               sub_b;
  logic [5:0]         slot;
  logic [CNT_W-1:0]   clk_cnt;
  logic [7:0]         pre;
  logic [27:0]        shift;
  logic [23:0]        hold_data;
  logic               hold_full;

  logic               hs_c;
  logic               launch_c;
  logic [5:0]         slot_nxt_c;
  logic               hold_full_nxt_c;
  logic               cs_bit_c;
  logic [26:0]        word_lo_c;
  logic [27:0]        word_c;
  logic [7:0]         pre_c;

  // Launch word (bits 4..31) and line-polarity-corrected preamble for the next subframe.
  always_comb begin
    hs_c            = i_valid & o_ready;
    launch_c        = (state == ST_RUN) && (clk_cnt == CNT_LAST) && (slot == SLOT_LAST);
    slot_nxt_c      = slot + 6'd1;
    hold_full_nxt_c = hs_c | (hold_full & ~launch_c);
    cs_bit_c        = (frame < 8'd32) ? CS_WORD[frame[4:0]] : 1'b0;
    word_lo_c       = {cs_bit_c, 1'b0, ~hold_full, (hold_full ? hold_data : 24'd0)};
    word_c          = {^word_lo_c, word_lo_c};
    if (sub_b)                 pre_c = PRE_Y;
    else if (frame == 8'd0)    pre_c = PRE_Z;
    else                       pre_c = PRE_X;
    pre_c = pre_c ^ {8{o_spdif}};
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= ST_WAIT;
      frame         <= 8'd0;
      sub_b         <= 1'b0;
      slot          <= 6'd0;
      clk_cnt       <= '0;
      pre           <= 8'd0;
      shift         <= 28'd0;
      hold_data     <= 24'd0;
      hold_full     <= 1'b0;
      o_ready       <= 1'b0;
      o_spdif       <= 1'b0;
      o_underrun    <= 1'b0;
      o_block_start <= 1'b0;
    end else begin
      o_underrun    <= 1'b0;
      o_block_start <= 1'b0;
      hold_full     <= hold_full_nxt_c;
      o_ready       <= ~hold_full_nxt_c;
      if (hs_c) hold_data <= i_data;

      case (state)
        ST_WAIT: begin
          o_spdif <= 1'b0;
          // Park the counters on the last clock of slot 63 so the next clock launches.
          if (hs_c) begin
            state   <= ST_RUN;
            slot    <= SLOT_LAST;
            clk_cnt <= CNT_LAST;
          end
        end
        ST_RUN: begin
          if (launch_c) begin
            pre           <= pre_c;
            shift         <= word_c;
            o_spdif       <= pre_c[7];
            slot          <= 6'd0;
            clk_cnt       <= '0;
            o_underrun    <= ~hold_full;
            o_block_start <= (frame == 8'd0) && !sub_b;
            sub_b         <= ~sub_b;
            if (sub_b) frame <= (frame == FRAME_LAST) ? 8'd0 : frame + 8'd1;
          end else if (clk_cnt == CNT_LAST) begin
            clk_cnt <= '0;
            slot    <= slot_nxt_c;
            // Preamble slots replay the stored pattern; data cells toggle at start, and mid-cell for a 1.
            if (slot_nxt_c < 6'd8) begin
              o_spdif <= pre[~slot_nxt_c[2:0]];
            end else if (!slot_nxt_c[0]) begin
              o_spdif <= ~o_spdif;
            end else begin
              o_spdif <= o_spdif ^ shift[0];
              shift   <= {1'b0, shift[27:1]};
            end
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end
        default: state <= ST_WAIT;
      endcase
    end
  end

endmodule
